// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with registered result, flags and a
// latched status register. An IDLE -> (MUL) -> HOLD FSM accepts one
// operation at a time and holds the result until the consumer takes it.
// Build option: define ALU_MUL_EN to make op 111 an iterative shift-add
// unsigned multiply taking WIDTH cycles. Without it, op 111 is a
// single-cycle logical shift right and no multiplier hardware is built.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_A,
    input  logic [WIDTH-1:0] val_B,
    input  logic [2:0]       alu_op,
    input  logic             flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [2:0]       znv,
    output logic [2:0]       status
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MUL_EN
        MUL  = 2'd2,
`endif
        HOLD = 2'd1
    } state_t;

    state_t           state;
    logic             we_q;       // flag_we captured at the handshake
    logic [WIDTH-1:0] res;        // single-cycle result from live operands
    logic             res_v;
    logic [2:0]       res_znv;
    logic [SW-1:0]    sh;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc;      // running partial product
    logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplier;   // multiplier, shifted right each step
    logic [SW-1:0]      cnt;      // step index 0..WIDTH-1
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mul_lo;
    logic [2:0]         mul_znv;
`endif

    assign sh = val_B[SW-1:0];

    // Single-cycle result and flags, computed from the operands presented at the handshake
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        res   = '0;
        res_v = 1'b0;
        unique case (alu_op)
            3'b000: begin
                res   = val_A + val_B;
                res_v = (val_A[WIDTH-1] == val_B[WIDTH-1]) && (res[WIDTH-1] != val_A[WIDTH-1]);
            end
            3'b001: begin
                res   = val_A - val_B;
                res_v = (val_A[WIDTH-1] != val_B[WIDTH-1]) && (res[WIDTH-1] != val_A[WIDTH-1]);
            end
            3'b010: res = val_A & val_B;
            3'b011: res = ~val_B;
            3'b100: res = val_A | val_B;
            3'b101: res = val_A ^ val_B;
            3'b110: res = val_A << sh;
`ifdef ALU_MUL_EN
            3'b111: res = '0;      // handled by the MUL state
`else
            3'b111: res = val_A >> sh;
`endif
            default: res = '0;
        endcase
        res_znv = {(res == '0), res[WIDTH-1], res_v};
    end

`ifdef ALU_MUL_EN
    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        mul_lo   = acc_next[WIDTH-1:0];
        mul_znv  = {(mul_lo == '0), mul_lo[WIDTH-1], |acc_next[2*WIDTH-1:WIDTH]};
    end
`endif

    // Control FSM with registered handshake outputs, result, flags and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            alu_out   <= '0;
            znv       <= '0;
            status    <= '0;
            we_q      <= 1'b0;
`ifdef ALU_MUL_EN
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        we_q     <= flag_we;
                        in_ready <= 1'b0;
`ifdef ALU_MUL_EN
                        if (alu_op == 3'b111) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, val_A};
                            mplier <= val_B;
                            cnt    <= '0;
                            state  <= MUL;
                        end else
`endif
                        begin
                            alu_out   <= res;
                            znv       <= res_znv;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SW'(WIDTH - 1)) begin
                        alu_out   <= mul_lo;
                        znv       <= mul_znv;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                        if (we_q) status <= znv;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with hand-computed results for alu_pipe
// (WIDTH=16). Covers reset, all ops, flag corner cases, backpressure and a
// mid-operation reset. Define ALU_MUL_EN to match an RTL built with it.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] val_A;
    logic [15:0] val_B;
    logic [2:0]  alu_op;
    logic        flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
    logic [2:0]  znv;
    logic [2:0]  status;

    int total = 0;
    int bad   = 0;
    int lat;

    alu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .val_A     (val_A),
        .val_B     (val_B),
        .alu_op    (alu_op),
        .flag_we   (flag_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .znv       (znv),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one operation and complete the handshake; scramble operands afterwards
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic we);
        @(negedge clk);
        check("ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_op   = op;
        val_A    = a;
        val_B    = b;
        flag_we  = we;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        val_A    = 16'($urandom);
        val_B    = 16'($urandom);
        alu_op   = 3'($urandom);
        flag_we  = 1'($urandom);
    endtask

    // Count cycles from the handshake edge until out_valid is seen, bounded
    task automatic wait_out(output int l);
        l = 1;
        while (out_valid !== 1'b1 && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Issue, check latency/result/flags, accept, check status and return to idle
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic we, input int exp_lat,
                          input logic [15:0] exp_out, input logic [2:0] exp_znv,
                          input logic [2:0] exp_status);
        issue(op, a, b, we);
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, 32'(alu_out), 32'(exp_out));
        check({tag, "_znv"}, 32'(znv), 32'(exp_znv));
        accept();
        check({tag, "_status"}, 32'(status), 32'(exp_status));
        check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        val_A     = '0;
        val_B     = '0;
        alu_op    = '0;
        flag_we   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_out", 32'(alu_out), 32'd0);
        check("rst_znv", 32'(znv), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // tag, op, A, B, we, latency, result, znv, status after acceptance
        run_op("add_ovf",  3'b000, 16'h7FFF, 16'h0001, 1'b1, 1, 16'h8000, 3'b011, 3'b011);
        run_op("sub_zero", 3'b001, 16'h0005, 16'h0005, 1'b0, 1, 16'h0000, 3'b100, 3'b011);

        // Backpressure: result held while a second request is presented during HOLD
        issue(3'b010, 16'hF0F0, 16'h0FF0, 1'b0);
        wait_out(lat);
        check("and_lat", 32'(lat), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = 3'b101;
        val_A    = 16'hFFFF;
        val_B    = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out", 32'(alu_out), 32'h00F0);
            check("bp_hs", {30'd0, out_valid, in_ready}, 32'b10);
        end
        check("bp_znv", 32'(znv), 32'(3'b000));
        in_valid = 1'b0;
        accept();
        check("bp_idle", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk);
        #1;
        check("bp_no_second", {30'd0, out_valid, in_ready}, 32'b01);
        check("bp_status", 32'(status), 32'(3'b011));

        run_op("shl3",     3'b110, 16'h0001, 16'h0013, 1'b0, 1, 16'h0008, 3'b000, 3'b011);
        run_op("shl15",    3'b110, 16'h0001, 16'h000F, 1'b0, 1, 16'h8000, 3'b010, 3'b011);
        run_op("shl_wrap", 3'b110, 16'h00FF, 16'h0010, 1'b0, 1, 16'h00FF, 3'b000, 3'b011);
        run_op("not",      3'b011, 16'h1234, 16'hFFFF, 1'b0, 1, 16'h0000, 3'b100, 3'b011);
        run_op("xor",      3'b101, 16'hA5A5, 16'h5A5A, 1'b0, 1, 16'hFFFF, 3'b010, 3'b011);
        run_op("or",       3'b100, 16'h1200, 16'h0034, 1'b0, 1, 16'h1234, 3'b000, 3'b011);
        run_op("sub_ovf",  3'b001, 16'h8000, 16'h0001, 1'b1, 1, 16'h7FFF, 3'b001, 3'b001);
        run_op("add_carry",3'b000, 16'hFFFF, 16'h0001, 1'b1, 1, 16'h0000, 3'b100, 3'b100);

`ifdef ALU_MUL_EN
        run_op("mul_ovf",  3'b111, 16'h0100, 16'h0100, 1'b1, 17, 16'h0000, 3'b101, 3'b101);
        run_op("mul_small",3'b111, 16'h0003, 16'h0005, 1'b0, 17, 16'h000F, 3'b000, 3'b101);
        // Reset during the fifth MUL cycle
        issue(3'b111, 16'h0003, 16'h0005, 1'b1);
        repeat (4) @(posedge clk);
`else
        run_op("shr4",     3'b111, 16'h8000, 16'h0004, 1'b0, 1, 16'h0800, 3'b000, 3'b100);
        // Reset while a result with flag_we=1 sits in HOLD
        issue(3'b000, 16'h7FFF, 16'h0001, 1'b1);
        @(posedge clk);
`endif
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_hs", {30'd0, out_valid, in_ready}, 32'b01);
        check("mid_rst_out", 32'(alu_out), 32'd0);
        check("mid_rst_status", 32'(status), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_rst", 3'b000, 16'h0002, 16'h0003, 1'b1, 1, 16'h0005, 3'b000, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
